mux4_rr_arbiter: RTL
====================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameters SHALL be:
- MAX_HOLD, 16, maximum cycles one owner may hold the grant; legal range 1..255.
REQ-002 Ports SHALL be:
- clk  input  1  sole clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per mux input; bit k requests in k.
- done  input  1  current owner releases its grant.
- grant  output  4  one-hot grant, or all zero.
- s1  output  1  mux select MSB.
- s0  output  1  mux select LSB.
- busy  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.
REQ-003 The block SHALL have one clock (clk), and its reset (rst) SHALL be asynchronous and active-high.
REQ-004 All outputs SHALL be registered. No output SHALL depend combinationally on any input.

Function
REQ-005 The FSM SHALL have two states, IDLE and BUSY. The internal state SHALL be: a 2-bit owner, a 2-bit round-robin pointer ptr, and an 8-bit hold counter hcnt.
REQ-006 In IDLE with req==0, the block SHALL stay in IDLE with grant=0, busy=0, and {s1,s0} unchanged.
REQ-007 In IDLE with req!=0, the block SHALL select the winner as the first set bit of req, scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-008 At the edge where req is sampled nonzero in IDLE, the block SHALL do all of the following, giving 1-cycle grant latency:
- grant = one-hot(winner); busy = 1; {s1,s0} = winner.
- hcnt = 1; ptr = (winner+1) mod 4; state = BUSY.
REQ-009 In BUSY, grant, {s1,s0} and owner SHALL hold constant. hcnt SHALL increment by 1 each cycle, saturating at 255.
REQ-010 In BUSY, a release condition SHALL be any of: done==1; req[owner]==0; hcnt==MAX_HOLD.
REQ-011 On a release, the next edge SHALL set grant=0, busy=0 and state=IDLE, and {s1,s0} SHALL retain the last owner.
REQ-012 After a release, a new grant SHALL appear no earlier than one further edge. This gives a mandatory one-cycle gap with grant=0 between consecutive owners.
REQ-013 timeout SHALL pulse high for exactly one cycle, coincident with the grant=0 edge, only when hcnt==MAX_HOLD AND done==0 AND req[owner]==1.
REQ-014 done or a dropped req occurring in the same cycle as hcnt==MAX_HOLD SHALL be treated as a normal release, with no timeout pulse.
REQ-015 done asserted in IDLE SHALL be ignored.
REQ-016 Requests from non-owners during BUSY SHALL NOT affect grant, owner or ptr.
REQ-017 A timed-out owner SHALL lose priority by the normal ptr rotation of REQ-008, not by masking. If it is the only requester, it SHALL be re-granted after the gap.
REQ-018 grant SHALL never have more than one bit set. When grant!=0, {s1,s0} SHALL equal the index of the set bit.
REQ-019 X or Z on req or done SHALL NOT be propagated into state by design intent; the bench drives only 0/1 on these.

Reset
REQ-020 While rst=1, regardless of clk, the block SHALL hold: grant=0, s1=0, s0=0, busy=0, timeout=0, state=IDLE, ptr=0, owner=0, hcnt=0.
REQ-021 Reset asserted during BUSY SHALL revoke the grant immediately (asynchronously), with no timeout pulse.
REQ-022 After rst deassertion, the first grant decision SHALL occur at the first rising edge where rst=0 and req!=0.

Verification
REQ-023 Reset, then req=4'b0101 held -> the grant sequence SHALL be:
- 0001 (s1s0=00) until done;
- gap;
- 0100 (s1s0=10);
- gap;
- 0001.
REQ-024 req=4'b1000 alone, done pulsed at hold cycle 3 -> grant=1000 for exactly 3 cycles, then 0000, with s1s0 staying 11 throughout.
REQ-025 MAX_HOLD=4, req=4'b0010 held, done=0 -> the bench SHALL observe:
- grant=0010 for 4 cycles;
- timeout=1 on the one cycle grant=0;
- re-grant 0010 one cycle later.
REQ-026 MAX_HOLD=4, done=1 in the 4th hold cycle -> release with timeout=0.
REQ-027 rst pulsed mid-BUSY while owner=2 -> grant=0 and s1s0=00 without waiting for a clock edge. Then with req=4'b0110, the first grant SHALL be 0010 (ptr reset to 0).
REQ-028 A random req/done run of 2000 cycles SHALL be checked by a scoreboard for:
- one-hot grant;
- {s1,s0} consistent with grant;
- the gap rule;
- round-robin order;
- no owner holding longer than MAX_HOLD.
A mux4to1 instance driven by s1/s0 SHALL pass the granted input unchanged.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter for four requesters. It drives a one-hot
// grant and a matching 2-bit mux select. A single owner holds the grant for at
// most MAX_HOLD cycles. Every output is a register.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state;
  logic [1:0] owner;
  logic [1:0] ptr;
  logic [7:0] hcnt;

  logic [1:0] win;
  logic       found;
  logic [1:0] idx;
  logic       at_limit;
  logic       release_now;

  // Winner is the first requester found scanning upward from ptr, modulo 4.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // The owner lets go on done, on dropping its request, or on reaching the hold limit.
  always_comb begin
    at_limit    = (hcnt == HOLD_LIM);
    release_now = done || !req[owner] || at_limit;
  end

  // Two-state grant FSM. The mux select keeps the last owner while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      hcnt    <= '0;
      grant   <= '0;
      s1      <= 1'b0;
      s0      <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner    <= win;
            grant    <= 4'b0001 << win;
            {s1, s0} <= win;
            busy     <= 1'b1;
            hcnt     <= 8'd1;
            ptr      <= win + 2'd1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            grant   <= '0;
            busy    <= 1'b0;
            hcnt    <= '0;
            state   <= IDLE;
            // Only a forced release raises timeout. A voluntary release in the
            // same cycle as the limit does not.
            timeout <= at_limit && !done && req[owner];
          end else if (hcnt != 8'hFF) begin
            hcnt <= hcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
